// File: rtl/fir_out_requant.sv
// rtl/fir_out_requant.sv - round/shift/saturate filter results into a small output FIFO
module fir_out_requant #(
  parameter int IN_WIDTH  = 36,
  parameter int OUT_WIDTH = 19,
  parameter int SHIFT     = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 ValidIn,
  input  logic                 ReadyIn,
  input  logic                 clr_status,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 ValidOut,
  output logic                 overflow,
  output logic [15:0]          sat_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [IN_WIDTH:0] ONE    = {{IN_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [IN_WIDTH:0] ROUND  = ONE << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] SAT_HI = (ONE << (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [IN_WIDTH:0] SAT_LO = -(ONE << (OUT_WIDTH - 1));

  // One extra bit keeps the rounding add from wrapping at the positive extreme.
  logic signed [IN_WIDTH:0] w_sum;
  logic signed [IN_WIDTH:0] w_shr;
  logic                     w_sat_hi;
  logic                     w_sat_lo;
  logic [OUT_WIDTH-1:0]     w_q;

  assign w_sum    = $signed({data_in[IN_WIDTH-1], data_in}) + ROUND;
  assign w_shr    = w_sum >>> SHIFT;
  assign w_sat_hi = w_shr > SAT_HI;
  assign w_sat_lo = w_shr < SAT_LO;

  always_comb begin
    w_q = w_shr[OUT_WIDTH-1:0];
    if (w_sat_hi) begin
      w_q = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (w_sat_lo) begin
      w_q = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  logic                 r_s1_valid;
  logic [OUT_WIDTH-1:0] r_s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      sat_count  <= '0;
    end else begin
      r_s1_valid <= ValidIn;
      if (ValidIn) begin
        r_s1_data <= w_q;
      end
      if (clr_status) begin
        sat_count <= '0;
      end else if (ValidIn && (w_sat_hi || w_sat_lo) && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

  logic [OUT_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && ReadyIn;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign w_push  = r_s1_valid && (!w_full || w_pop);
  assign w_drop  = r_s1_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_s1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (clr_status) begin
        overflow <= 1'b0;
      end else if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ValidOut = !w_empty;
  assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule
